house_occupancy_ctrl: RTL and testbench
=======================================

Name: house_occupancy_ctrl

Overview:
Owns the 8-bit houses register, one bit per goal slot at the top of the Frogger board, and drives it onto the bus read by the all-houses-full comparator. The block records frog arrivals, flags arrivals into occupied houses as deaths, and detects a full board from the comparator's active-low output. On a full board it runs a blink celebration, clears the houses and advances the level. It sits between the frog-position logic and the comparator/display path.

Parameters:
BLINK_TOGGLES, 6, number of display toggles during celebration (even, 2..15)
TICKS_PER_TOGGLE, 15, frame ticks per toggle (1..255)
LEVEL_MAX, 9, saturating maximum of the level counter (≤15)

Ports:
CC_HOUSECTRL_CLOCK_50  in  1  system clock
CC_HOUSECTRL_RESET_InHigh  in  1  reset, asynchronous, active-high
CC_HOUSECTRL_tick_In  in  1  one-cycle frame tick
CC_HOUSECTRL_arrive_In  in  1  one-cycle pulse: frog reached the house row
CC_HOUSECTRL_col_InBUS  in  3  house index of the arrival (0..7)
CC_HOUSECTRL_fullLow_In  in  1  comparator output, 0 = all 8 houses occupied
CC_HOUSECTRL_houses_OutBUS  out  8  registered occupancy, feeds the comparator
CC_HOUSECTRL_display_OutBUS  out  8  occupancy as shown on screen (blinks in celebration)
CC_HOUSECTRL_score_Out  out  1  one-cycle pulse: valid arrival
CC_HOUSECTRL_death_Out  out  1  one-cycle pulse: arrival into an occupied house
CC_HOUSECTRL_levelup_Out  out  1  one-cycle pulse: level advanced
CC_HOUSECTRL_level_OutBUS  out  4  current level
CC_HOUSECTRL_busy_Out  out  1  1 while in CELEBRATE or CLEAR

Behaviour:
- Reset (async, any state, including mid-celebration): state=PLAY, houses=0, display=0, level=0, tick/toggle counters=0, all pulses=0, busy=0.
- States: PLAY, CELEBRATE, CLEAR.
- PLAY with fullLow_In=1 and arrive_In=1:
  - houses[col]=0: the bit is set at the next edge and score_Out is 1 for that cycle.
  - houses[col]=1: death_Out is 1 for that cycle and houses is unchanged.
  - At most one pulse per arrive.
- PLAY with fullLow_In=0: go to CELEBRATE at the next edge and clear the counters. Any arrive in that cycle is ignored (no score, no death). Full detection has priority.
- The comparator is combinational on the registered houses, so fullLow falls one cycle after the setting edge. The FSM enters CELEBRATE two edges after the final arrive.
- CELEBRATE:
  - arrive_In is ignored.
  - On each tick, the tick counter increments. When it reaches TICKS_PER_TOGGLE it resets to 0, display inverts (0xFF↔0x00) and the toggle counter increments.
  - After BLINK_TOGGLES toggles, go to CLEAR.
  - Display starts at 0xFF on entry.
- CLEAR (one cycle): houses=0 and display=0 at the next edge; level increments, saturating at LEVEL_MAX; levelup_Out is 1 for this cycle even when saturated; return to PLAY.
- In PLAY, display equals houses.
- busy_Out is registered: 1 exactly while state≠PLAY.
- All outputs are registered. Pulses are never asserted for more than one cycle.

Optional Feature:
Macro HOUSECTRL_FLY_EN.
- Defined: adds ports CC_HOUSECTRL_fly_OutBUS[2:0] and CC_HOUSECTRL_bonus_Out.
  - The fly index advances mod 8 every 64 ticks while in PLAY, skipping occupied houses; if none are free it holds. Reset sets it to 0.
  - A valid arrival at col==fly also pulses bonus_Out in the same cycle as score_Out.
- Undefined: no fly logic and no extra ports; behaviour is otherwise identical.

Decomposition:
- Shared package: state encoding constants (PLAY=2'd0, CELEBRATE=2'd1, CLEAR=2'd2), HOUSE_COUNT=8, HOUSES_ALL_FULL=8'hFF.
- One sub-module: house_blink_timer, containing the tick and toggle counters with a done output, instantiated by the FSM.

Test Plan:
- Reset, then arrive col=3 → score pulse 1 cycle; houses=0x08; display=0x08.
- houses=0x08, arrive col=3 → death pulse 1 cycle; houses stays 0x08; no score.
- Fill cols 0..7 with comparator model attached → CELEBRATE entered 2 edges after the last arrive; busy=1; with TICKS_PER_TOGGLE=2 the display shows 0xFF,0x00,… ×6; then CLEAR gives houses=0, level=1, levelup 1 cycle, busy=0.
- During CELEBRATE, arrive col=0 → no score/death pulse; houses stays 0xFF.
- Assert reset midway through CELEBRATE → immediately houses=0, level=0, busy=0, PLAY; a subsequent arrive scores normally.
- Ten full-board cycles with LEVEL_MAX=9 → level saturates at 9; the tenth levelup still pulses.

Source files
------------

// File: rtl/house_occupancy_ctrl_pkg.sv
// Shared types and constants for the Frogger house-occupancy controller.
// Also holds the fly-index search helper used when HOUSECTRL_FLY_EN is defined.
package house_occupancy_ctrl_pkg;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    CELEBRATE = 2'd1,
    CLEAR     = 2'd2
  } state_t;

  localparam int          HOUSE_COUNT     = 8;
  localparam logic [7:0]  HOUSES_ALL_FULL = 8'hFF;

  // Next free house after cur, searching upward with wrap; holds cur if none is free.
  function automatic logic [2:0] next_free_house(input logic [7:0] occ, input logic [2:0] cur);
    logic [2:0] idx;
    logic [2:0] nxt;
    nxt = cur;
    for (int k = HOUSE_COUNT - 1; k >= 1; k--) begin
      idx = cur + 3'(k);
      if (!occ[idx]) nxt = idx;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/house_occupancy_ctrl_blink_timer.sv
// house_blink_timer: tick and toggle counters pacing the full-board celebration.
// Counters are held at zero whenever run is low, so each celebration starts fresh.
module house_blink_timer
  import house_occupancy_ctrl_pkg::*;
#(
  parameter int BLINK_TOGGLES    = 6,
  parameter int TICKS_PER_TOGGLE = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic tick,
  output logic toggle,
  output logic done
);

  localparam logic [7:0] TICK_LAST   = 8'(TICKS_PER_TOGGLE - 1);
  localparam logic [3:0] TOGGLE_LAST = 4'(BLINK_TOGGLES - 1);

  logic [7:0] tick_cnt;
  logic [3:0] toggle_cnt;

  // toggle fires on the tick that would bring tick_cnt up to TICKS_PER_TOGGLE.
  assign toggle = run && tick && (tick_cnt == TICK_LAST);
  assign done   = toggle && (toggle_cnt == TOGGLE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt   <= '0;
      toggle_cnt <= '0;
    end else if (!run) begin
      tick_cnt   <= '0;
      toggle_cnt <= '0;
    end else if (tick) begin
      if (tick_cnt == TICK_LAST) begin
        tick_cnt   <= '0;
        toggle_cnt <= toggle_cnt + 4'd1;
      end else begin
        tick_cnt <= tick_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/house_occupancy_ctrl.sv
// house_occupancy_ctrl: owns the houses register, scores/kills arrivals, celebrates a full board.
// Optional fly/bonus feature is enabled by defining HOUSECTRL_FLY_EN.
module house_occupancy_ctrl
  import house_occupancy_ctrl_pkg::*;
#(
  parameter int BLINK_TOGGLES    = 6,
  parameter int TICKS_PER_TOGGLE = 15,
  parameter int LEVEL_MAX        = 9
) (
  input  logic       CC_HOUSECTRL_CLOCK_50,
  input  logic       CC_HOUSECTRL_RESET_InHigh,
  input  logic       CC_HOUSECTRL_tick_In,
  input  logic       CC_HOUSECTRL_arrive_In,
  input  logic [2:0] CC_HOUSECTRL_col_InBUS,
  input  logic       CC_HOUSECTRL_fullLow_In,
  output logic [7:0] CC_HOUSECTRL_houses_OutBUS,
  output logic [7:0] CC_HOUSECTRL_display_OutBUS,
  output logic       CC_HOUSECTRL_score_Out,
  output logic       CC_HOUSECTRL_death_Out,
  output logic       CC_HOUSECTRL_levelup_Out,
  output logic [3:0] CC_HOUSECTRL_level_OutBUS,
  output logic       CC_HOUSECTRL_busy_Out
`ifdef HOUSECTRL_FLY_EN
  ,
  output logic [2:0] CC_HOUSECTRL_fly_OutBUS,
  output logic       CC_HOUSECTRL_bonus_Out
`endif
);

  localparam logic [3:0] LEVEL_TOP = 4'(LEVEL_MAX);

  logic       clk;
  logic       rst;
  state_t     state;
  logic [7:0] houses;
  logic [7:0] col_onehot;
  logic       blink_toggle;
  logic       blink_done;

  assign clk        = CC_HOUSECTRL_CLOCK_50;
  assign rst        = CC_HOUSECTRL_RESET_InHigh;
  assign col_onehot = 8'b1 << CC_HOUSECTRL_col_InBUS;

  assign CC_HOUSECTRL_houses_OutBUS = houses;

  house_blink_timer #(
    .BLINK_TOGGLES   (BLINK_TOGGLES),
    .TICKS_PER_TOGGLE(TICKS_PER_TOGGLE)
  ) u_blink (
    .clk   (clk),
    .rst   (rst),
    .run   (state == CELEBRATE),
    .tick  (CC_HOUSECTRL_tick_In),
    .toggle(blink_toggle),
    .done  (blink_done)
  );

  // NOTE: all state here uses non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                       <= PLAY;
      houses                      <= '0;
      CC_HOUSECTRL_display_OutBUS <= '0;
      CC_HOUSECTRL_level_OutBUS   <= '0;
      CC_HOUSECTRL_score_Out      <= 1'b0;
      CC_HOUSECTRL_death_Out      <= 1'b0;
      CC_HOUSECTRL_levelup_Out    <= 1'b0;
      CC_HOUSECTRL_busy_Out       <= 1'b0;
    end else begin
      CC_HOUSECTRL_score_Out   <= 1'b0;
      CC_HOUSECTRL_death_Out   <= 1'b0;
      CC_HOUSECTRL_levelup_Out <= 1'b0;
      case (state)
        PLAY: begin
          // A full board wins over a simultaneous arrival.
          if (!CC_HOUSECTRL_fullLow_In) begin
            state                       <= CELEBRATE;
            CC_HOUSECTRL_busy_Out       <= 1'b1;
            CC_HOUSECTRL_display_OutBUS <= HOUSES_ALL_FULL;
          end else if (CC_HOUSECTRL_arrive_In) begin
            if ((houses & col_onehot) != 8'h00) begin
              CC_HOUSECTRL_death_Out <= 1'b1;
            end else begin
              houses                      <= houses | col_onehot;
              CC_HOUSECTRL_display_OutBUS <= houses | col_onehot;
              CC_HOUSECTRL_score_Out      <= 1'b1;
            end
          end
        end
        CELEBRATE: begin
          if (blink_toggle) begin
            CC_HOUSECTRL_display_OutBUS <= ~CC_HOUSECTRL_display_OutBUS;
            if (blink_done) state <= CLEAR;
          end
        end
        CLEAR: begin
          state                       <= PLAY;
          houses                      <= '0;
          CC_HOUSECTRL_display_OutBUS <= '0;
          CC_HOUSECTRL_levelup_Out    <= 1'b1;
          CC_HOUSECTRL_busy_Out       <= 1'b0;
          if (CC_HOUSECTRL_level_OutBUS < LEVEL_TOP)
            CC_HOUSECTRL_level_OutBUS <= CC_HOUSECTRL_level_OutBUS + 4'd1;
        end
        default: begin
          state                 <= PLAY;
          CC_HOUSECTRL_busy_Out <= 1'b0;
        end
      endcase
    end
  end

`ifdef HOUSECTRL_FLY_EN
  logic [5:0] fly_cnt;

  // The fly hops every 64 play ticks; a scoring arrival on its house earns a bonus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fly_cnt                 <= '0;
      CC_HOUSECTRL_fly_OutBUS <= '0;
      CC_HOUSECTRL_bonus_Out  <= 1'b0;
    end else begin
      CC_HOUSECTRL_bonus_Out <= 1'b0;
      if (state == PLAY) begin
        if (CC_HOUSECTRL_tick_In) begin
          fly_cnt <= fly_cnt + 6'd1;
          if (fly_cnt == 6'd63)
            CC_HOUSECTRL_fly_OutBUS <= next_free_house(houses, CC_HOUSECTRL_fly_OutBUS);
        end
        if (CC_HOUSECTRL_fullLow_In && CC_HOUSECTRL_arrive_In &&
            ((houses & col_onehot) == 8'h00) &&
            (CC_HOUSECTRL_col_InBUS == CC_HOUSECTRL_fly_OutBUS))
          CC_HOUSECTRL_bonus_Out <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_house_occupancy_ctrl.sv
// Randomized self-checking bench for house_occupancy_ctrl with an all-full comparator attached.
// Expectations come from a board/level model and tick arithmetic for the celebration.
module tb_house_occupancy_ctrl;

  localparam int TPT    = 2;
  localparam int TOGS   = 6;
  localparam int LVLMAX = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       arrive = 1'b0;
  logic [2:0] col = 3'd0;
  logic       full_low;
  logic [7:0] houses, display;
  logic       score, death, levelup, busy;
  logic [3:0] level;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_houses = 8'h00;
  int         m_level  = 0;

  always #5 clk = ~clk;

  assign full_low = ~(&houses);

  house_occupancy_ctrl #(
    .BLINK_TOGGLES(TOGS), .TICKS_PER_TOGGLE(TPT), .LEVEL_MAX(LVLMAX)
  ) dut (
    .CC_HOUSECTRL_CLOCK_50      (clk),
    .CC_HOUSECTRL_RESET_InHigh  (rst),
    .CC_HOUSECTRL_tick_In       (tick),
    .CC_HOUSECTRL_arrive_In     (arrive),
    .CC_HOUSECTRL_col_InBUS     (col),
    .CC_HOUSECTRL_fullLow_In    (full_low),
    .CC_HOUSECTRL_houses_OutBUS (houses),
    .CC_HOUSECTRL_display_OutBUS(display),
    .CC_HOUSECTRL_score_Out     (score),
    .CC_HOUSECTRL_death_Out     (death),
    .CC_HOUSECTRL_levelup_Out   (levelup),
    .CC_HOUSECTRL_level_OutBUS  (level),
    .CC_HOUSECTRL_busy_Out      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_play(input string tag);
    check({tag, "_houses"}, 32'(houses), 32'(m_houses));
    check({tag, "_display"}, 32'(display), 32'(m_houses));
    check({tag, "_level"}, 32'(level), 32'(m_level));
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Board must not be full on entry, so the comparator reads 1 and the arrival counts.
  task automatic arrive_at(input logic [2:0] c);
    logic hit;
    hit    = m_houses[c];
    arrive = 1'b1;
    col    = c;
    tick   = 1'($urandom_range(1));
    step();
    arrive = 1'b0;
    tick   = 1'b0;
    check("arr_score", 32'(score), 32'(!hit));
    check("arr_death", 32'(death), 32'(hit));
    m_houses[c] = 1'b1;
    check_play("arr");
  endtask

  task automatic idle_cycle();
    step();
    check("idle_score", 32'(score), 32'd0);
    check("idle_death", 32'(death), 32'd0);
    check("idle_levelup", 32'(levelup), 32'd0);
    check_play("idle");
  endtask

  task automatic fill_board();
    int guard;
    guard = 0;
    while (m_houses != 8'hFF) begin
      logic [2:0] c;
      c = 3'($urandom_range(7));
      if (guard > 60) begin
        for (int i = 0; i < 8; i++) if (!m_houses[i]) c = 3'(i);
      end
      arrive_at(c);
      guard++;
      if (m_houses != 8'hFF && $urandom_range(3) == 0) idle_cycle();
    end
  endtask

  // Called one edge after the final arrive; abort_after_ticks >= 0 resets mid-celebration.
  task automatic celebrate(input int abort_after_ticks);
    int ticks, cyc;
    logic [7:0] exp_disp;
    check("fill_busy_before", 32'(busy), 32'd0);
    arrive = 1'($urandom_range(1));
    col    = 3'($urandom_range(7));
    step();
    arrive = 1'b0;
    check("enter_busy", 32'(busy), 32'd1);
    check("enter_display", 32'(display), 32'hFF);
    check("enter_score", 32'(score), 32'd0);
    check("enter_death", 32'(death), 32'd0);
    ticks = 0;
    cyc   = 0;
    while (ticks / TPT < TOGS && cyc < 500) begin
      if (abort_after_ticks >= 0 && ticks >= abort_after_ticks) begin
        #2 rst = 1'b1;
        #1;
        check("rst_houses", 32'(houses), 32'h00);
        check("rst_display", 32'(display), 32'h00);
        check("rst_level", 32'(level), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        #2 rst = 1'b0;
        m_houses = 8'h00;
        m_level  = 0;
        step();
        return;
      end
      tick   = 1'($urandom_range(1));
      arrive = 1'($urandom_range(1));
      col    = 3'($urandom_range(7));
      step();
      if (tick) ticks++;
      tick   = 1'b0;
      arrive = 1'b0;
      cyc++;
      exp_disp = ((ticks / TPT) % 2 == 0) ? 8'hFF : 8'h00;
      check("cel_display", 32'(display), 32'(exp_disp));
      check("cel_houses", 32'(houses), 32'hFF);
      check("cel_busy", 32'(busy), 32'd1);
      check("cel_score", 32'(score), 32'd0);
      check("cel_death", 32'(death), 32'd0);
    end
    if (cyc >= 500) check("cel_timeout", 32'(cyc), 32'd0);
    step();
    m_houses = 8'h00;
    m_level  = (m_level < LVLMAX) ? m_level + 1 : LVLMAX;
    check("clr_levelup", 32'(levelup), 32'd1);
    check_play("clr");
    idle_cycle();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_play("reset");
    check("reset_score", 32'(score), 32'd0);
    check("reset_levelup", 32'(levelup), 32'd0);
    #3 rst = 1'b0;
    step();

    arrive_at(3'd3);
    check("first_houses", 32'(houses), 32'h08);
    idle_cycle();
    arrive_at(3'd3);
    check("death_houses", 32'(houses), 32'h08);
    idle_cycle();

    for (int round = 0; round < 10; round++) begin
      fill_board();
      celebrate(-1);
    end
    check("sat_level", 32'(level), 32'(LVLMAX));

    fill_board();
    celebrate(int'($urandom_range(1, 7)));
    check_play("post_rst");
    arrive_at(3'($urandom_range(7)));
    fill_board();
    celebrate(-1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
